// File: rtl/adc_spi_resp.sv
// adc_spi_resp: SPI responder that emulates an 8-channel 12-bit ADC with a one-frame address latency.
// Define ADC_RESP_ERR_EN to add the sticky protocol-error flag (iERR_CLR / oERR).
module adc_spi_resp #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iCS_n,
  input  logic        iSCLK,
  input  logic        iDIN,
  input  logic [95:0] iCH_DATA,
  output logic        oDOUT,
  output logic        oDOUT_OE,
  output logic [2:0]  oCH_SEL,
  output logic        oFRAME_DONE
`ifdef ADC_RESP_ERR_EN
  ,
  input  logic        iERR_CLR,
  output logic        oERR
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]             state;
  logic [SYNC_STAGES-1:0] csSync;
  logic [SYNC_STAGES-1:0] sclkSync;
  logic [SYNC_STAGES-1:0] dinSync;
  logic                   csPrev;
  logic                   sclkPrev;
  logic                   csS;
  logic                   sclkS;
  logic                   dinS;
  logic                   csFall;
  logic                   csRise;
  logic                   sclkRise;
  logic                   sclkFall;
  logic [4:0]             edgeCnt;
  logic [15:0]            shiftReg;
  logic [2:0]             pendAddr;
  logic [2:0]             chSel;
  logic                   frameDone;
  logic [11:0]            chWord [8];
  logic [11:0]            selWord;

  for (genvar g = 0; g < 8; g++) begin : gCh
    assign chWord[g] = iCH_DATA[g*12 +: 12];
  end

  assign selWord = chWord[chSel];

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      csSync   <= '1;
      sclkSync <= '1;
      dinSync  <= '0;
      csPrev   <= 1'b1;
      sclkPrev <= 1'b1;
    end else begin
      csSync   <= {csSync[SYNC_STAGES-2:0], iCS_n};
      sclkSync <= {sclkSync[SYNC_STAGES-2:0], iSCLK};
      dinSync  <= {dinSync[SYNC_STAGES-2:0], iDIN};
      csPrev   <= csS;
      sclkPrev <= sclkS;
    end
  end

  assign csS      = csSync[SYNC_STAGES-1];
  assign sclkS    = sclkSync[SYNC_STAGES-1];
  assign dinS     = dinSync[SYNC_STAGES-1];
  assign csFall   = csPrev & ~csS;
  assign csRise   = ~csPrev & csS;
  assign sclkRise = ~sclkPrev & sclkS;
  assign sclkFall = sclkPrev & ~sclkS;

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state     <= IDLE;
      edgeCnt   <= '0;
      shiftReg  <= '0;
      pendAddr  <= '0;
      chSel     <= '0;
      frameDone <= 1'b0;
    end else begin
      frameDone <= 1'b0;
      case (state)
        IDLE: begin
          if (csFall) begin
            state    <= SHIFT;
            edgeCnt  <= '0;
            pendAddr <= '0;
            shiftReg <= {4'b0000, selWord};
          end
        end
        SHIFT: begin
          // CS rise wins over any SCLK edge seen in the same cycle
          if (csRise) begin
            state <= IDLE;
          end else begin
            if (sclkFall) shiftReg <= {shiftReg[14:0], 1'b0};
            if (sclkRise) begin
              edgeCnt <= edgeCnt + 5'd1;
              case (edgeCnt)
                5'd2:    pendAddr[2] <= dinS;
                5'd3:    pendAddr[1] <= dinS;
                5'd4:    pendAddr[0] <= dinS;
                default: ;
              endcase
              if (edgeCnt == 5'd15) begin
                chSel     <= pendAddr;
                frameDone <= 1'b1;
                state     <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (csRise) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oDOUT       = (state == SHIFT) & shiftReg[15];
  assign oDOUT_OE    = (state != IDLE);
  assign oCH_SEL     = chSel;
  assign oFRAME_DONE = frameDone;

`ifdef ADC_RESP_ERR_EN
  logic errSet;

  assign errSet = ((state == SHIFT) & csRise) | ((state == HOLD) & ~csRise & sclkRise);

  always_ff @(posedge iCLK) begin
    if (!iRST)         oERR <= 1'b0;
    else if (errSet)   oERR <= 1'b1;
    else if (iERR_CLR) oERR <= 1'b0;
  end
`endif

endmodule
